// File: rtl/snake_pkg.sv
// Shared types and widths for the snake collision logic.
package snake_pkg;

  typedef enum logic {
    RUN       = 1'b0,
    GAME_OVER = 1'b1
  } state_e;

  localparam int HIT_CNT_W = 16;
  localparam int GRACE_W   = 8;

endpackage

// File: rtl/frame_hit_accum.sv
// Per-frame overlap evidence: saturating head/apple pixel count plus sticky
// self/wall flags, restarted from the current pixel at every frame boundary.
module frame_hit_accum
  import snake_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clear,
  input  logic                 frame_start,
  input  logic                 ov_hit,
  input  logic                 self_hit,
  input  logic                 wall_hit,
  output logic [HIT_CNT_W-1:0] ov_cnt,
  output logic                 self_seen,
  output logic                 wall_seen
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ov_cnt    <= '0;
      self_seen <= 1'b0;
      wall_seen <= 1'b0;
    end else if (clear) begin
      ov_cnt    <= '0;
      self_seen <= 1'b0;
      wall_seen <= 1'b0;
    end else if (frame_start) begin
      // The boundary pixel already belongs to the new frame.
      ov_cnt    <= {{(HIT_CNT_W-1){1'b0}}, ov_hit};
      self_seen <= self_hit;
      wall_seen <= wall_hit;
    end else begin
      if (ov_hit && (ov_cnt != '1))
        ov_cnt <= ov_cnt + 1'b1;
      self_seen <= self_seen | self_hit;
      wall_seen <= wall_seen | wall_hit;
    end
  end

endmodule

// File: rtl/snake_collision_detect.sv
// Frame-level collision decision for the snake game: one registered event per
// frame and a sticky game-over state. Define SNAKE_WALL_WRAP_EN for a wrap-around playfield.
module snake_collision_detect
  import snake_pkg::*;
#(
  parameter int MIN_HIT_PIXELS = 4,
  parameter int GRACE_FRAMES   = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 startOfFrame,
  input  logic                 restart,
  input  logic                 head_draw,
  input  logic                 body_draw,
  input  logic                 apple_draw,
  input  logic                 border_draw,
  output logic                 apple_collision,
  output logic                 self_collision,
  output logic                 wall_collision,
  output logic                 game_over,
  output logic [HIT_CNT_W-1:0] hit_pixels
);

  state_e               state;
  logic [GRACE_W-1:0]   grace;
  logic [HIT_CNT_W-1:0] ov_cnt;
  logic                 self_seen;
  logic                 wall_seen;
  logic                 wall_hit;

`ifdef SNAKE_WALL_WRAP_EN
  assign wall_hit = 1'b0;
`else
  assign wall_hit = head_draw & border_draw;
`endif

  frame_hit_accum u_accum (
    .clk         (clk),
    .reset       (reset),
    .clear       (state == GAME_OVER),
    .frame_start (startOfFrame),
    .ov_hit      (head_draw & apple_draw),
    .self_hit    (head_draw & body_draw),
    .wall_hit    (wall_hit),
    .ov_cnt      (ov_cnt),
    .self_seen   (self_seen),
    .wall_seen   (wall_seen)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= RUN;
      grace           <= GRACE_W'(GRACE_FRAMES);
      apple_collision <= 1'b0;
      self_collision  <= 1'b0;
      wall_collision  <= 1'b0;
      game_over       <= 1'b0;
      hit_pixels      <= '0;
    end else begin
      apple_collision <= 1'b0;
      self_collision  <= 1'b0;
      wall_collision  <= 1'b0;
      case (state)
        RUN: begin
          if (startOfFrame) begin
            hit_pixels <= ov_cnt;
            if (grace != '0)
              grace <= grace - 1'b1;
            // Death outranks an apple in the same frame.
            if (wall_seen) begin
              wall_collision <= 1'b1;
              state          <= GAME_OVER;
              game_over      <= 1'b1;
            end else if (self_seen && (grace == '0)) begin
              self_collision <= 1'b1;
              state          <= GAME_OVER;
              game_over      <= 1'b1;
            end else if (ov_cnt >= HIT_CNT_W'(MIN_HIT_PIXELS)) begin
              apple_collision <= 1'b1;
            end
          end
        end
        GAME_OVER: begin
          if (startOfFrame)
            hit_pixels <= '0;
          if (restart) begin
            state     <= RUN;
            game_over <= 1'b0;
            grace     <= GRACE_W'(GRACE_FRAMES);
          end
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_snake_collision_detect.sv
// Directed bench for snake_collision_detect (default parameters); expectations
// follow SNAKE_WALL_WRAP_EN when the macro is defined.
module tb_snake_collision_detect;

  logic        clk = 1'b0;
  logic        reset;
  logic        startOfFrame, restart;
  logic        head_draw, body_draw, apple_draw, border_draw;
  logic        apple_collision, self_collision, wall_collision, game_over;
  logic [15:0] hit_pixels;

  int vectors = 0;
  int miscompares = 0;

  snake_collision_detect dut (
    .clk             (clk),
    .reset           (reset),
    .startOfFrame    (startOfFrame),
    .restart         (restart),
    .head_draw       (head_draw),
    .body_draw       (body_draw),
    .apple_draw      (apple_draw),
    .border_draw     (border_draw),
    .apple_collision (apple_collision),
    .self_collision  (self_collision),
    .wall_collision  (wall_collision),
    .game_over       (game_over),
    .hit_pixels      (hit_pixels)
  );

  always #5 clk = ~clk;

  // Drive one cycle of inputs at the falling edge, return just after the rising edge.
  task automatic applyStimulus(input logic sof, input logic rs, input logic h,
                               input logic b, input logic a, input logic w);
    @(negedge clk);
    startOfFrame = sof;
    restart      = rs;
    head_draw    = h;
    body_draw    = b;
    apple_draw   = a;
    border_draw  = w;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0, 0);
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] observed,
                             input logic [15:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic checkPulses(input string tag, input logic ea, input logic es,
                             input logic ew, input logic eg);
    checkOutput({tag, ".apple"}, {15'd0, apple_collision}, {15'd0, ea});
    checkOutput({tag, ".self"},  {15'd0, self_collision},  {15'd0, es});
    checkOutput({tag, ".wall"},  {15'd0, wall_collision},  {15'd0, ew});
    checkOutput({tag, ".game_over"}, {15'd0, game_over},   {15'd0, eg});
  endtask

  initial begin
    reset = 1'b1;
    startOfFrame = 0; restart = 0;
    head_draw = 0; body_draw = 0; apple_draw = 0; border_draw = 0;
    #12;
    checkPulses("reset", 0, 0, 0, 0);
    checkOutput("reset.hit_pixels", hit_pixels, 16'd0);
    @(negedge clk);
    reset = 1'b0;
    idle(2);

    // Test 1: 10 overlaps -> apple pulse one clk after the boundary.
    applyStimulus(1, 0, 0, 0, 0, 0);                 // sof#1, grace 8->7
    for (int i = 0; i < 10; i++) applyStimulus(0, 0, 1, 0, 1, 0);
    idle(3);
    checkPulses("t1.before", 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0);                 // sof#2, grace 7->6
    checkPulses("t1.pulse", 1, 0, 0, 0);
    checkOutput("t1.hit_pixels", hit_pixels, 16'd10);
    idle(1);
    checkPulses("t1.after", 0, 0, 0, 0);

    // Test 2: 3 overlaps is below the threshold.
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 1, 0, 1, 0);
    idle(2);
    applyStimulus(1, 0, 0, 0, 0, 0);                 // sof#3, grace 6->5
    checkPulses("t2", 0, 0, 0, 0);
    checkOutput("t2.hit_pixels", hit_pixels, 16'd3);

    // Test 3: self hit during grace ignored, then fatal once grace expires.
    applyStimulus(0, 0, 1, 1, 0, 0);
    idle(2);
    applyStimulus(1, 0, 0, 0, 0, 0);                 // sof#4, grace 5
    checkPulses("t3.grace", 0, 0, 0, 0);
    for (int f = 5; f <= 9; f++) begin                // sof#5..#9, grace 4..0
      idle(3);
      applyStimulus(1, 0, 0, 0, 0, 0);
    end
    checkPulses("t3.discarded", 0, 0, 0, 0);
    applyStimulus(0, 0, 1, 1, 0, 0);
    idle(2);
    applyStimulus(1, 0, 0, 0, 0, 0);                 // sof#10, grace 0
    checkPulses("t3.self", 0, 1, 0, 1);
    idle(1);
    checkPulses("t3.sticky", 0, 0, 0, 1);
    for (int i = 0; i < 5; i++) applyStimulus(0, 0, 1, 0, 1, 0);
    applyStimulus(1, 0, 0, 0, 0, 0);
    checkPulses("t3.over_frame", 0, 0, 0, 1);
    checkOutput("t3.over_hit_pixels", hit_pixels, 16'd0);

    // Test 5: restart together with startOfFrame wins, grace reloaded.
    idle(2);
    applyStimulus(1, 1, 0, 0, 0, 0);
    checkPulses("t5.restart", 0, 0, 0, 0);
    applyStimulus(0, 0, 1, 1, 0, 0);
    idle(2);
    applyStimulus(1, 0, 0, 0, 0, 0);                 // grace 8 -> self ignored
    checkPulses("t5.grace_reloaded", 0, 0, 0, 0);
    applyStimulus(0, 1, 0, 0, 0, 0);
    checkPulses("t5.restart_in_run", 0, 0, 0, 0);

    // Test 4: wall and apple in the same frame.
    applyStimulus(0, 0, 1, 0, 0, 1);
    for (int i = 0; i < 10; i++) applyStimulus(0, 0, 1, 0, 1, 0);
    idle(2);
    applyStimulus(1, 0, 0, 0, 0, 0);
`ifdef SNAKE_WALL_WRAP_EN
    checkPulses("t4.wrap", 1, 0, 0, 0);
`else
    checkPulses("t4.wall", 0, 0, 1, 1);
`endif
    checkOutput("t4.hit_pixels", hit_pixels, 16'd10);
    applyStimulus(0, 1, 0, 0, 0, 0);
    checkPulses("t4.restarted", 0, 0, 0, 0);

    // Test 6: asynchronous reset during the apple pulse.
    idle(1);
    applyStimulus(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) applyStimulus(0, 0, 1, 0, 1, 0);
    applyStimulus(1, 0, 0, 0, 0, 0);
    checkPulses("t6.pulse", 1, 0, 0, 0);
    reset = 1'b1;
    #1;
    checkPulses("t6.async", 0, 0, 0, 0);
    checkOutput("t6.async_hit_pixels", hit_pixels, 16'd0);
    @(negedge clk);
    reset = 1'b0;
    applyStimulus(1, 0, 0, 0, 0, 0);
    idle(5);
    applyStimulus(1, 0, 0, 0, 0, 0);
    checkPulses("t6.empty", 0, 0, 0, 0);
    checkOutput("t6.hit_pixels", hit_pixels, 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
